spi_sd_engine: RTL and testbench

//  Parametrised successor to the byte-wide SPI controller core: serialises bytes over
//  1-bit SPI (mode 0) or 4-bit SD bus (DAT[3:0]), with programmable SCLK divider,
//  NUM_SS chip selects and a per-lane SD CRC16. Sits behind the register/bus front-end,

---
 rtl/spi_sd_engine.sv | 204 ++++++++++++++++++++
 tb/tb_spi_sd_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sd_engine.sv
// Byte-serial SPI (mode 0) / 4-bit SD data engine with programmable SCLK divider,
// registered active-low slave selects and a CRC16-CCITT register per data lane.
module spi_sd_engine #(
    parameter int NUM_SS  = 4,
    parameter int DIV_W   = 8,
    parameter bit QUAD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_quad,
    input  logic [NUM_SS-1:0] cfg_ss,
    input  logic              crc_clr,
    input  logic              crc_src,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [7:0]        tx_data,
    input  logic              tx_write,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    output logic              busy,
    output logic              sclk,
    output logic [NUM_SS-1:0] _ss,
    output logic [3:0]        sdo,
    output logic              sdo_oe,
    input  logic [3:0]        sdi,
    output logic [63:0]       crc_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic              quad_q, quad_d;
    logic              src_q, src_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic [3:0]        sdo_q, sdo_d;
    logic              sdo_oe_q, sdo_oe_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic [3:0][15:0]  crc_q, crc_d;

    logic              accept;
    logic              load_quad;
    logic [3:0]        crc_bits;
    logic [7:0]        tx_next;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // In 1-bit mode the unused data lines idle high; MOSI rides on lane 0.
    function automatic logic [3:0] lane_drive(input logic [7:0] sh, input logic quad);
        return quad ? sh[7:4] : {3'b111, sh[7]};
    endfunction

    assign tx_ready  = !reset && (state_q == S_IDLE || state_q == S_DONE);
    assign accept    = tx_valid && tx_ready;
    assign load_quad = cfg_quad && QUAD_EN;

    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        quad_d    = quad_q;
        src_d     = src_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        sdo_oe_d  = sdo_oe_q;
        ss_d      = ss_q;
        crc_d     = crc_q;
        crc_bits  = src_q ? sdi : sdo_q;
        tx_next   = quad_q ? {tx_sh_q[3:0], 4'b0000} : {tx_sh_q[6:0], 1'b0};

        case (state_q)
            S_IDLE: begin
                ss_d = ~cfg_ss;
            end
            S_LOW: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                    rx_sh_d = quad_q ? {rx_sh_q[3:0], sdi} : {rx_sh_q[6:0], sdi[0]};
                    if (quad_q) begin
                        for (int k = 0; k < 4; k++) begin
                            crc_d[k] = crc16_step(crc_q[k], crc_bits[k]);
                        end
                    end else begin
                        crc_d[0] = crc16_step(crc_q[0], crc_bits[0]);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        state_d   = S_DONE;
                        rx_data_d = rx_sh_q;
                        sdo_d     = 4'hF;
                        sdo_oe_d  = 1'b0;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 3'd1;
                        tx_sh_d = tx_next;
                        sdo_d   = lane_drive(tx_next, quad_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept is legal in IDLE and in DONE, the latter giving back-to-back bytes.
        if (accept) begin
            state_d  = S_LOW;
            div_d    = cfg_div;
            cnt_d    = '0;
            bit_d    = load_quad ? 3'd1 : 3'd7;
            quad_d   = load_quad;
            src_d    = crc_src;
            tx_sh_d  = tx_data;
            sdo_d    = lane_drive(tx_data, load_quad);
            sdo_oe_d = load_quad && tx_write;
            sclk_d   = 1'b0;
        end

        if (crc_clr) begin
            crc_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            quad_q    <= 1'b0;
            src_q     <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 4'hF;
            sdo_oe_q  <= 1'b0;
            ss_q      <= '1;
            crc_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            quad_q    <= quad_d;
            src_q     <= src_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            sdo_oe_q  <= sdo_oe_d;
            ss_q      <= ss_d;
            crc_q     <= crc_d;
        end
    end

    assign rx_valid = !reset && (state_q == S_DONE);
    assign busy     = (state_q == S_LOW) || (state_q == S_HIGH);
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign _ss      = ss_q;
    assign sdo      = sdo_q;
    assign sdo_oe   = sdo_oe_q;
    assign crc_out  = crc_q;

endmodule

// File: tb/tb_spi_sd_engine.sv
// Directed bench for spi_sd_engine: a behavioural SPI/SD slave feeds sdi and
// records sdo on every rising sclk; each scenario task compares against constants.
module tb_spi_sd_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cfg_div = '0;
    logic        cfg_quad = 1'b0;
    logic [3:0]  cfg_ss = '0;
    logic        crc_clr = 1'b0;
    logic        crc_src = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = '0;
    logic        tx_write = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        sclk;
    logic [3:0]  ss_n;
    logic [3:0]  sdo;
    logic        sdo_oe;
    logic [3:0]  sdi;
    logic [63:0] crc_out;

    int passed = 0;
    int total  = 0;

    spi_sd_engine #(.NUM_SS(4), .DIV_W(8), .QUAD_EN(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_div  (cfg_div),
        .cfg_quad (cfg_quad),
        .cfg_ss   (cfg_ss),
        .crc_clr  (crc_clr),
        .crc_src  (crc_src),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_write (tx_write),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk     (sclk),
        ._ss      (ss_n),
        .sdo      (sdo),
        .sdo_oe   (sdo_oe),
        .sdi      (sdi),
        .crc_out  (crc_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: sdi presents the stream word shifted by the rises seen so far.
    logic [31:0] sdi_word = '0;
    int          sdi_base = 0;
    logic        sdi_quad = 1'b0;
    logic [31:0] sdi_cur;
    int          rise_total = 0;
    int          last_rise_cyc = 0;
    int          prev_rise_cyc = 0;
    int          oe_total = 0;
    int          upper_bad = 0;
    logic        sclk_prev = 1'b0;
    logic [31:0] mosi_cap = '0;
    logic [31:0] nib_cap = '0;

    assign sdi_cur = sdi_word << (sdi_quad ? 4 * (rise_total - sdi_base) : (rise_total - sdi_base));
    assign sdi     = sdi_quad ? sdi_cur[31:28] : {3'b111, sdi_cur[31]};

    always @(negedge clk) begin
        if (sdo_oe === 1'b1) oe_total++;
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            rise_total++;
            prev_rise_cyc = last_rise_cyc;
            last_rise_cyc = cyc;
            mosi_cap = {mosi_cap[30:0], sdo[0]};
            nib_cap  = {nib_cap[27:0], sdo};
            if (!sdi_quad && sdo[3:1] !== 3'b111) upper_bad++;
        end
        sclk_prev = sclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers one byte, waits for acceptance, then counts negedges until rx_valid.
    task automatic xfer(input logic [7:0] d, input logic q, input logic w,
                        output logic [7:0] rx, output int lat);
        int guard;
        tx_data  = d;
        cfg_quad = q;
        tx_write = w;
        tx_valid = 1'b1;
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        lat = 1;
        while (rx_valid !== 1'b1 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        rx = rx_data;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else passed++;
        total++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else passed++;
        total++; if (ss_n !== 4'hF) $display("FAIL reset_ss: got %h want f", ss_n); else passed++;
        total++; if (sdo !== 4'hF || sdo_oe !== 1'b0) $display("FAIL reset_sdo: got sdo=%h oe=%b want f/0", sdo, sdo_oe); else passed++;
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0)
            $display("FAIL reset_rx: got rv=%b rd=%h busy=%b want 0/00/0", rx_valid, rx_data, busy); else passed++;
        total++; if (crc_out !== 64'h0) $display("FAIL reset_crc: got %h want 0", crc_out); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (tx_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", tx_ready); else passed++;
    endtask

    task automatic test_read_1bit;
        logic [7:0] exp_b [4];
        logic [7:0] rx;
        int         lat;
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cfg_div  = 8'd0;
        sdi_quad = 1'b0;
        sdi_word = 32'hDEAD_BEEF;
        sdi_base = rise_total;
        for (int i = 0; i < 4; i++) begin
            xfer(exp_b[i], 1'b0, 1'b0, rx, lat);
            total++; if (rx !== exp_b[i]) $display("FAIL read1_data[%0d]: got %h want %h", i, rx, exp_b[i]); else passed++;
            total++; if (lat !== 17) $display("FAIL read1_latency[%0d]: got %0d want 17", i, lat); else passed++;
        end
    endtask

    task automatic test_write_1bit;
        logic [7:0] wr_b [4];
        logic [7:0] rx;
        int         lat;
        int         upper0;
        wr_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        cfg_div  = 8'd255;
        sdi_quad = 1'b0;
        sdi_word = '0;
        sdi_base = rise_total;
        upper0   = upper_bad;
        for (int i = 0; i < 4; i++) begin
            xfer(wr_b[i], 1'b0, 1'b1, rx, lat);
        end
        total++; if (mosi_cap !== 32'h1234_5678) $display("FAIL write1_mosi: got %h want 12345678", mosi_cap); else passed++;
        total++; if (last_rise_cyc - prev_rise_cyc !== 512)
            $display("FAIL write1_sclk_period: got %0d want 512", last_rise_cyc - prev_rise_cyc); else passed++;
        total++; if (lat !== 4097) $display("FAIL write1_latency: got %0d want 4097", lat); else passed++;
        total++; if (upper_bad !== upper0) $display("FAIL write1_sdo_upper: got %0d bad rises want 0", upper_bad - upper0); else passed++;
    endtask

    task automatic test_ss;
        int ss_bad;
        int guard;
        cfg_div = 8'd1;
        cfg_ss  = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        total++; if (ss_n !== 4'b1110) $display("FAIL ss_idle: got %b want 1110", ss_n); else passed++;
        tx_data  = 8'h00;
        cfg_quad = 1'b0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL ss_busy: got %b want 1", busy); else passed++;
        cfg_ss = 4'b0010;
        ss_bad = 0;
        guard  = 0;
        while (rx_valid !== 1'b1 && guard < 100) begin
            if (ss_n !== 4'b1110) ss_bad++;
            @(negedge clk);
            guard++;
        end
        total++; if (ss_bad !== 0 || guard >= 100) $display("FAIL ss_hold: got %0d changes (guard %0d) want 0", ss_bad, guard); else passed++;
        total++; if (ss_n !== 4'b1110) $display("FAIL ss_at_rx_valid: got %b want 1110", ss_n); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (ss_n !== 4'b1101) $display("FAIL ss_after: got %b want 1101", ss_n); else passed++;
        cfg_ss = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_crc;
        logic [7:0] rx;
        int         lat;
        cfg_div  = 8'd0;
        sdi_quad = 1'b0;
        crc_src  = 1'b0;
        crc_clr  = 1'b1;
        @(negedge clk);
        crc_clr  = 1'b0;
        total++; if (crc_out !== 64'h0) $display("FAIL crc_clear: got %h want 0", crc_out); else passed++;
        for (int i = 0; i < 512; i++) begin
            xfer(8'hFF, 1'b0, 1'b1, rx, lat);
        end
        total++; if (crc_out[15:0] !== 16'h7FA1) $display("FAIL crc_lane0: got %h want 7fa1", crc_out[15:0]); else passed++;
        total++; if (crc_out[63:16] !== 48'h0) $display("FAIL crc_upper_lanes: got %h want 0", crc_out[63:16]); else passed++;
        crc_clr = 1'b1;
        xfer(8'hFF, 1'b0, 1'b1, rx, lat);
        crc_clr = 1'b0;
        total++; if (crc_out !== 64'h0) $display("FAIL crc_clr_priority: got %h want 0", crc_out); else passed++;
    endtask

    task automatic test_quad;
        logic [7:0] rx;
        int         lat;
        int         oe0;
        cfg_div  = 8'd1;
        sdi_quad = 1'b1;
        sdi_word = '0;
        sdi_base = rise_total;
        crc_src  = 1'b0;
        oe0      = oe_total;
        xfer(8'hA5, 1'b1, 1'b1, rx, lat);
        total++; if (nib_cap[7:0] !== 8'hA5) $display("FAIL quad_write_nibbles: got %h want a5", nib_cap[7:0]); else passed++;
        total++; if (oe_total - oe0 !== 8) $display("FAIL quad_write_oe_cycles: got %0d want 8", oe_total - oe0); else passed++;
        total++; if (lat !== 9) $display("FAIL quad_latency: got %0d want 9", lat); else passed++;
        total++; if (sdo_oe !== 1'b0) $display("FAIL quad_oe_done: got %b want 0", sdo_oe); else passed++;

        crc_src = 1'b1;
        crc_clr = 1'b1;
        @(negedge clk);
        crc_clr  = 1'b0;
        sdi_word = 32'h3C00_0000;
        sdi_base = rise_total;
        oe0      = oe_total;
        xfer(8'h00, 1'b1, 1'b0, rx, lat);
        total++; if (rx !== 8'h3C) $display("FAIL quad_read_data: got %h want 3c", rx); else passed++;
        total++; if (oe_total - oe0 !== 0) $display("FAIL quad_read_oe: got %0d cycles want 0", oe_total - oe0); else passed++;
        total++; if (crc_out !== 64'h1021_1021_2042_2042)
            $display("FAIL quad_crc_lanes: got %h want 1021102120422042", crc_out); else passed++;
        crc_src  = 1'b0;
        sdi_quad = 1'b0;
        cfg_quad = 1'b0;
    endtask

    task automatic test_reset_mid_byte;
        logic [7:0] rx;
        int         lat;
        int         rv_seen;
        cfg_div  = 8'd3;
        cfg_ss   = 4'b0100;
        sdi_quad = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (tx_ready !== 1'b0) $display("FAIL midreset_tx_ready: got %b want 0", tx_ready); else passed++;
        @(negedge clk);
        total++; if (sclk !== 1'b0 || ss_n !== 4'hF || busy !== 1'b0)
            $display("FAIL midreset_state: got sclk=%b ss=%b busy=%b want 0/1111/0", sclk, ss_n, busy); else passed++;
        reset = 1'b0;
        rv_seen = 0;
        repeat (40) begin
            if (rx_valid !== 1'b0) rv_seen++;
            @(negedge clk);
        end
        total++; if (rv_seen !== 0) $display("FAIL midreset_no_rx_valid: got %0d pulses want 0", rv_seen); else passed++;
        sdi_word = 32'h5A00_0000;
        sdi_base = rise_total;
        xfer(8'h00, 1'b0, 1'b0, rx, lat);
        total++; if (rx !== 8'h5A) $display("FAIL midreset_next_data: got %h want 5a", rx); else passed++;
        total++; if (lat !== 65) $display("FAIL midreset_next_latency: got %0d want 65", lat); else passed++;
    endtask

    initial begin
        test_reset;
        test_read_1bit;
        test_write_1bit;
        test_ss;
        test_crc;
        test_quad;
        test_reset_mid_byte;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
